// File: rtl/axis_gen_pkg.sv
// Shared definitions for the AXIS descriptor generator and its receive-side measurement block.
package axis_gen_pkg;

    localparam int unsigned LEN_LSB   = 0;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned PAUSE_LSB = 16;
    localparam int unsigned PAUSE_W   = 32;
    localparam int unsigned CH_LSB    = 48;
    localparam int unsigned DESC_CH_W = 10;

    localparam int unsigned ERR_KEEP = 0;
    localparam int unsigned ERR_TID  = 1;
    localparam int unsigned ERR_OVF  = 2;
    localparam int unsigned ERR_DATA = 3;
    localparam int unsigned ERR_W    = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_PACKET = 1'b1
    } rx_state_t;

    typedef struct packed {
        logic [DESC_CH_W-1:0] channel;
        logic [PAUSE_W-1:0]   pause;
        logic [LEN_W-1:0]     length;
    } descriptor_t;

endpackage

// File: rtl/axis_keep_decode.sv
// Combinational tkeep decode: byte count, all-ones and LSB-contiguous (2^k-1) flags.
module axis_keep_decode #(
    parameter int unsigned KEEP_W = 4,
    parameter int unsigned CNT_W  = $clog2(KEEP_W + 1)
) (
    input  logic [KEEP_W-1:0] i_tkeep,
    output logic [CNT_W-1:0]  o_popcount,
    output logic              o_all_ones,
    output logic              o_lsb_contig
);

    logic [KEEP_W-1:0] w_plus1;

    always_comb begin
        o_popcount = '0;
        for (int i = 0; i < int'(KEEP_W); i++) begin
            o_popcount = o_popcount + CNT_W'(i_tkeep[i]);
        end
    end

    // A value of the form 2^k-1 has no bit in common with itself plus one.
    assign w_plus1      = i_tkeep + KEEP_W'(1);
    assign o_all_ones   = &i_tkeep;
    assign o_lsb_contig = ((i_tkeep & w_plus1) == '0);

endmodule

// File: rtl/axis_to_descriptor.sv
// AXIS sink that measures channel, byte length and preceding idle gap of each packet and emits a descriptor.
// Optional tdata check against a reference stream is enabled by defining AXIS_DATA_CHECK_EN.
module axis_to_descriptor
    import axis_gen_pkg::*;
#(
    parameter int unsigned ID_WIDTH    = 10,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TKEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ID_WIDTH-1:0]    s_axis_tid_i,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata_i,
    input  logic                   s_axis_tvalid_i,
    input  logic                   s_axis_tlast_i,
    input  logic [TKEEP_WIDTH-1:0] s_axis_tkeep_i,
    output logic                   s_axis_tready_o,
    output logic [47+ID_WIDTH:0]   out_descriptor_data_o,
    output logic [ERR_W-1:0]       out_descriptor_err_o,
    output logic                   out_descriptor_valid_o,
    input  logic                   out_descriptor_ready_i
`ifdef AXIS_DATA_CHECK_EN
    ,
    input  logic [DATA_WIDTH-1:0]  psrand_data_i,
    output logic                   psrand_next_o
`endif
);

    localparam int unsigned CNT_W = $clog2(TKEEP_WIDTH + 1);

    rx_state_t           r_state, w_state_next;
    logic [ID_WIDTH-1:0] r_tid;
    logic [PAUSE_W-1:0]  r_gap_cnt, r_gap_cap;
    logic [16:0]         r_len_acc;
    logic [ERR_W-1:0]    r_err_acc;

    logic                w_beat, w_first, w_emit, w_data_err;
    logic [CNT_W-1:0]    w_popcnt;
    logic                w_all_ones, w_lsb_contig;
    logic [17:0]         w_len_sum;
    logic [16:0]         w_len_tot;
    logic [LEN_W-1:0]    w_len_rep;
    logic [ID_WIDTH-1:0] w_ch;
    logic [PAUSE_W-1:0]  w_gap;
    logic [ERR_W-1:0]    w_cur_err;

    axis_keep_decode #(.KEEP_W(TKEEP_WIDTH), .CNT_W(CNT_W)) u_keep_decode (
        .i_tkeep      (s_axis_tkeep_i),
        .o_popcount   (w_popcnt),
        .o_all_ones   (w_all_ones),
        .o_lsb_contig (w_lsb_contig)
    );

    // Stall input only while a descriptor is pending and the consumer refuses it.
    assign s_axis_tready_o = ~(out_descriptor_valid_o & ~out_descriptor_ready_i);
    assign w_beat  = s_axis_tvalid_i & s_axis_tready_o;
    assign w_first = (r_state == ST_IDLE);
    assign w_emit  = w_beat & s_axis_tlast_i;

    assign w_len_sum = 18'(w_first ? 17'd0 : r_len_acc) + 18'(w_popcnt);
    assign w_len_tot = w_len_sum[17] ? 17'h1FFFF : w_len_sum[16:0];
    assign w_len_rep = w_len_tot[16] ? 16'hFFFF : w_len_tot[15:0];
    assign w_ch      = w_first ? s_axis_tid_i : r_tid;
    assign w_gap     = w_first ? r_gap_cnt : r_gap_cap;

`ifdef AXIS_DATA_CHECK_EN
    always_comb begin
        w_data_err = 1'b0;
        for (int b = 0; b < int'(TKEEP_WIDTH); b++) begin
            if (s_axis_tkeep_i[b] && (s_axis_tdata_i[8*b +: 8] != psrand_data_i[8*b +: 8])) begin
                w_data_err = 1'b1;
            end
        end
    end
    assign psrand_next_o = w_beat;
`else
    logic w_unused_data;
    assign w_unused_data = ^s_axis_tdata_i;
    assign w_data_err    = 1'b0;
`endif

    always_comb begin
        w_cur_err           = '0;
        w_cur_err[ERR_KEEP] = s_axis_tlast_i ? (~w_lsb_contig | (s_axis_tkeep_i == '0)) : ~w_all_ones;
        w_cur_err[ERR_TID]  = ~w_first & (s_axis_tid_i != r_tid);
        w_cur_err[ERR_OVF]  = w_len_tot[16];
        w_cur_err[ERR_DATA] = w_data_err;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_beat && !s_axis_tlast_i) w_state_next = ST_PACKET;
            ST_PACKET: if (w_emit)                    w_state_next = ST_IDLE;
            default:                                  w_state_next = ST_IDLE;
        endcase
    end

    // Per-packet measurement; gap counts only between packets and saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tid     <= '0;
            r_gap_cnt <= '0;
            r_gap_cap <= '0;
            r_len_acc <= '0;
            r_err_acc <= '0;
        end else if (w_beat) begin
            if (w_first) begin
                r_tid     <= s_axis_tid_i;
                r_gap_cap <= r_gap_cnt;
            end
            r_gap_cnt <= '0;
            r_len_acc <= w_emit ? 17'd0 : w_len_tot;
            r_err_acc <= w_emit ? '0 : (r_err_acc | w_cur_err);
        end else if (w_first && (r_gap_cnt != '1)) begin
            r_gap_cnt <= r_gap_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_descriptor_data_o  <= '0;
            out_descriptor_err_o   <= '0;
            out_descriptor_valid_o <= 1'b0;
        end else if (w_emit) begin
            out_descriptor_data_o  <= {w_ch, w_gap, w_len_rep};
            out_descriptor_err_o   <= r_err_acc | w_cur_err;
            out_descriptor_valid_o <= 1'b1;
        end else if (out_descriptor_ready_i) begin
            out_descriptor_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_to_descriptor.sv
// Directed, table-driven bench for axis_to_descriptor; define AXIS_DATA_CHECK_EN to cover the data check.
module tb_axis_to_descriptor;

    localparam int unsigned IDW = 10;
    localparam int unsigned DW  = 32;
    localparam int unsigned KW  = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [IDW-1:0] tid = '0;
    logic [DW-1:0]  tdata = '0;
    logic           tvalid = 1'b0;
    logic           tlast = 1'b0;
    logic [KW-1:0]  tkeep = '0;
    logic           tready;
    logic [47+IDW:0] d_data;
    logic [3:0]     d_err;
    logic           d_valid;
    logic           d_ready = 1'b1;
    logic [DW-1:0]  psrand = '0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int             idle;
        logic [IDW-1:0] tid;
        logic [KW-1:0]  keep;
        logic           last;
        logic [IDW-1:0] ech;
        logic [31:0]    egap;
        logic [15:0]    elen;
        logic [3:0]     eerr;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

`ifdef AXIS_DATA_CHECK_EN
    logic psrand_next;
`else
    logic unused_tb;
    assign unused_tb = ^psrand;
`endif

    axis_to_descriptor dut (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_tid_i           (tid),
        .s_axis_tdata_i         (tdata),
        .s_axis_tvalid_i        (tvalid),
        .s_axis_tlast_i         (tlast),
        .s_axis_tkeep_i         (tkeep),
        .s_axis_tready_o        (tready),
        .out_descriptor_data_o  (d_data),
        .out_descriptor_err_o   (d_err),
        .out_descriptor_valid_o (d_valid),
        .out_descriptor_ready_i (d_ready)
`ifdef AXIS_DATA_CHECK_EN
        ,
        .psrand_data_i          (psrand),
        .psrand_next_o          (psrand_next)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_desc(input string name, input logic [IDW-1:0] ch, input logic [31:0] gap,
                              input logic [15:0] len, input logic [3:0] err);
        chk({name, "_valid"}, 64'(d_valid), 64'd1);
        chk({name, "_ch"},    64'(d_data[57:48]), 64'(ch));
        chk({name, "_gap"},   64'(d_data[47:16]), 64'(gap));
        chk({name, "_len"},   64'(d_data[15:0]), 64'(len));
        chk({name, "_err"},   64'(d_err), 64'(err));
    endtask

    task automatic send_beat(input logic [IDW-1:0] b_tid, input logic [KW-1:0] b_keep,
                             input logic b_last, input logic [DW-1:0] corrupt);
        logic acc;
        acc    = 1'b0;
        tid    = b_tid;
        tkeep  = b_keep;
        tlast  = b_last;
        tdata  = $urandom;
        psrand = tdata ^ corrupt;
        tvalid = 1'b1;
        for (int c = 0; c < 20 && !acc; c++) begin
            acc = tready;
            @(posedge clk);
            #1;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        if (!acc) chk("beat_accept_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // idle, tid, keep, last, exp ch, exp gap, exp len, exp err
        vq.push_back('{5, 10'd3, 4'b0011, 1'b1, 10'd3, 32'd5, 16'd2, 4'b0000});
        for (int p = 0; p < 3; p++) begin
            vq.push_back('{(p == 0) ? 2 : 0, 10'd1, 4'b1111, 1'b0, 10'd0, 32'd0, 16'd0, 4'b0000});
            vq.push_back('{0, 10'd1, 4'b1111, 1'b0, 10'd0, 32'd0, 16'd0, 4'b0000});
            vq.push_back('{0, 10'd1, 4'b0001, 1'b1, 10'd1, (p == 0) ? 32'd2 : 32'd0, 16'd9, 4'b0000});
        end
        vq.push_back('{0, 10'd4, 4'b1111, 1'b0, 10'd0, 32'd0, 16'd0, 4'b0000});
        vq.push_back('{0, 10'd4, 4'b0111, 1'b0, 10'd0, 32'd0, 16'd0, 4'b0000});
        vq.push_back('{0, 10'd4, 4'b0011, 1'b1, 10'd4, 32'd0, 16'd9, 4'b0001});
        vq.push_back('{0, 10'd4, 4'b1111, 1'b0, 10'd0, 32'd0, 16'd0, 4'b0000});
        vq.push_back('{0, 10'd4, 4'b0101, 1'b1, 10'd4, 32'd0, 16'd6, 4'b0001});
        vq.push_back('{0, 10'd2, 4'b1111, 1'b0, 10'd0, 32'd0, 16'd0, 4'b0000});
        vq.push_back('{0, 10'd5, 4'b1111, 1'b0, 10'd0, 32'd0, 16'd0, 4'b0000});
        vq.push_back('{0, 10'd2, 4'b1111, 1'b1, 10'd2, 32'd0, 16'd12, 4'b0010});
        vq.push_back('{1, 10'd7, 4'b1111, 1'b1, 10'd7, 32'd1, 16'd4, 4'b0000});
        vq.push_back('{0, 10'd7, 4'b0000, 1'b1, 10'd7, 32'd0, 16'd0, 4'b0001});
        vq.push_back('{0, 10'h3FF, 4'b1111, 1'b1, 10'h3FF, 32'd0, 16'd4, 4'b0000});

        // Reset values while reset is held.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", 64'(tready), 64'd1);
        chk("rst_valid",  64'(d_valid), 64'd0);
        chk("rst_data",   64'(d_data), 64'd0);
        chk("rst_err",    64'(d_err), 64'd0);
        reset = 1'b0;

        foreach (vq[i]) begin
            repeat (vq[i].idle) begin
                @(posedge clk);
                #1;
            end
            send_beat(vq[i].tid, vq[i].keep, vq[i].last, '0);
            if (vq[i].last) check_desc($sformatf("vec%0d", i), vq[i].ech, vq[i].egap, vq[i].elen, vq[i].eerr);
        end

        // Backpressure: second packet waits while the first descriptor is held.
        @(posedge clk);
        #1;
        d_ready = 1'b0;
        send_beat(10'd8, 4'b1111, 1'b1, '0);
        check_desc("bp_a", 10'd8, 32'd1, 16'd4, 4'b0000);
        chk("bp_tready_low", 64'(tready), 64'd0);
        tid = 10'd9; tkeep = 4'b1111; tlast = 1'b0; tdata = $urandom; psrand = tdata; tvalid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("bp_hold_valid", 64'(d_valid), 64'd1);
        chk("bp_hold_ch", 64'(d_data[57:48]), 64'd8);
        chk("bp_hold_tready", 64'(tready), 64'd0);
        d_ready = 1'b1;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        chk("bp_a_consumed", 64'(d_valid), 64'd0);
        send_beat(10'd9, 4'b0011, 1'b1, '0);
        check_desc("bp_b", 10'd9, 32'd3, 16'd6, 4'b0000);

        // Length boundaries: exactly 65537 bytes overflows, exactly 65535 does not.
        @(posedge clk);
        #1;
        for (int b = 0; b < 16384; b++) send_beat(10'd11, 4'b1111, 1'b0, '0);
        send_beat(10'd11, 4'b0001, 1'b1, '0);
        check_desc("ovf", 10'd11, 32'd1, 16'hFFFF, 4'b0100);
        for (int b = 0; b < 16383; b++) send_beat(10'd12, 4'b1111, 1'b0, '0);
        send_beat(10'd12, 4'b0111, 1'b1, '0);
        check_desc("max_len", 10'd12, 32'd0, 16'hFFFF, 4'b0000);

        // Reset in the middle of a packet discards it.
        send_beat(10'd1, 4'b1111, 1'b0, '0);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(d_valid), 64'd0);
        chk("mid_rst_data", 64'(d_data), 64'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_tready", 64'(tready), 64'd1);
        reset = 1'b0;
        send_beat(10'd6, 4'b1111, 1'b0, '0);
        chk("mid_rst_no_desc", 64'(d_valid), 64'd0);
        send_beat(10'd6, 4'b0001, 1'b1, '0);
        check_desc("post_rst", 10'd6, 32'd0, 16'd5, 4'b0000);

`ifdef AXIS_DATA_CHECK_EN
        send_beat(10'd2, 4'b0111, 1'b1, 32'hFF00_0000);
        check_desc("data_masked", 10'd2, 32'd0, 16'd3, 4'b0000);
        send_beat(10'd2, 4'b1111, 1'b0, 32'h0000_1000);
        send_beat(10'd2, 4'b1111, 1'b1, '0);
        check_desc("data_bad", 10'd2, 32'd0, 16'd8, 4'b1000);
`endif

        @(posedge clk);
        #1;
        chk("final_idle_valid", 64'(d_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_to_descriptor.md
Name: axis_to_descriptor

Overview:
AXI-Stream sink and measurement block; the receive-side counterpart of the descriptor-driven packet generator. Accepts packets on an AXIS slave port and measures each one: channel (tid), byte length (from tkeep), and idle gap before it. Emits one descriptor per packet in the generator's {channel, pause[31:0], length[15:0]} layout, plus protocol error flags. Used in loopback benches and on-chip self-test to compare received traffic against issued descriptors.

Parameters:
ID_WIDTH, 10, tid width / descriptor channel field width
DATA_WIDTH, 32, tdata width in bits, multiple of 8, 8..512
TKEEP_WIDTH, DATA_WIDTH/8, tkeep width in bits

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
s_axis_tid_i  in  ID_WIDTH  stream channel
s_axis_tdata_i  in  DATA_WIDTH  stream data
s_axis_tvalid_i  in  1  beat valid
s_axis_tlast_i  in  1  last beat of packet
s_axis_tkeep_i  in  TKEEP_WIDTH  byte enables
s_axis_tready_o  out  1  beat accepted when high with tvalid
out_descriptor_data_o  out  48+ID_WIDTH  {channel, gap[31:0], length[15:0]}
out_descriptor_err_o  out  4  {DATA, OVF, TID, KEEP} error flags for this packet
out_descriptor_valid_o  out  1  descriptor valid
out_descriptor_ready_i  in  1  descriptor consumer ready

Behaviour:
- One clock; reset asynchronous active-high. Reset values: s_axis_tready_o=1, out_descriptor_valid_o=0, out data/err=0; state=IDLE, byte accumulator=0, gap counter=0, error accumulator=0.
- Beat accepted = s_axis_tvalid_i & s_axis_tready_o. s_axis_tready_o = ~(out_descriptor_valid_o & ~out_descriptor_ready_i) (combinational from ready_i; no comb path from tvalid).
- States: IDLE (between packets), PACKET (inside multi-beat packet).
- IDLE: gap counter +1 every cycle without an accepted beat, saturating at 32'hFFFFFFFF. Accepted beat: capture tid; tlast=1 -> emit descriptor, stay IDLE; tlast=0 -> go PACKET.
- PACKET: accepted tlast beat -> emit descriptor, go IDLE; gap counter cleared to 0 on that same edge.
- Gap = cycles strictly between tlast acceptance and the next first-beat acceptance; back-to-back packets report 0. The first packet after reset counts from reset release. Gap reported belongs to the packet that follows it.
- Length = sum of popcount(tkeep) over all beats, 17-bit internal. If >16'hFFFF, report 16'hFFFF and set OVF.
- KEEP error: non-last beat with tkeep != all ones, or last beat with tkeep zero or not of form 2^k-1 (LSB-contiguous).
- TID error: any beat whose tid differs from the tid captured on the first beat; the descriptor reports the first-beat tid.
- Emit: output register loads {channel, gap, length}, err=accumulated|current-beat flags; valid=1. Register holds until out_descriptor_ready_i. Handshake and new emit in the same cycle: reload, valid stays 1. Error accumulator is cleared on emit.
- Latency: descriptor valid one cycle after the tlast beat is accepted.
- Reset mid-packet discards the partial packet; no descriptor is emitted.

Optional Feature:
AXIS_DATA_CHECK_EN: adds ports psrand_data_i (in, DATA_WIDTH) and psrand_next_o (out, 1, equal to beat accepted). On each accepted beat, compare tdata with psrand_data_i on enabled bytes only; any mismatch sets DATA in err. Without the macro, these ports are absent and the DATA flag is tied 0.

Decomposition:
- Package axis_gen_pkg: descriptor field offsets/widths (LEN_LSB=0, PAUSE_LSB=16, CH_LSB=48); err bit indices (ERR_KEEP=0, ERR_TID=1, ERR_OVF=2, ERR_DATA=3); state enum; packed descriptor struct shared with the generator.
- One sub-module, axis_keep_decode: combinational popcount of tkeep, plus all_ones and lsb_contiguous flags.

Test Plan:
- Reset release, 5 idle cycles, then one beat with tid=3, tkeep=4'b0011, tlast -> descriptor {ch=3, gap=5, len=2}, err=0.
- Three back-to-back packets of 9 bytes each (beats 1111,1111,0001) -> each len=9; gap=0 for the 2nd and 3rd.
- Middle beat with tkeep=4'b0111 -> err KEEP=1, len still summed; last beat with tkeep=4'b0101 -> KEEP=1.
- tid changes 2 to 5 mid-packet -> ch=2, TID=1; next clean packet has err=0.
- out_descriptor_ready_i held low while the second packet ends -> tready drops; no beat lost; both descriptors emitted in order.
- Reset asserted mid-packet -> no descriptor; next packet len is correct; with AXIS_DATA_CHECK_EN, a corrupted byte sets DATA=1.
